// File: rtl/serial_mult_seq.sv
// Sequential shift-and-add multiplier with put/get handshake, one multiplier bit per cycle.
// Optional macro SERIAL_MULT_SIGNED_EN switches to two's-complement operands (magnitude + sign).
module serial_mult_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 put,
  input  logic [WIDTH-1:0]     idata,
  input  logic                 get,
  output logic                 ready,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid
);

  localparam int PW = 2 * WIDTH;

  // Handshake: an operand is taken on a rising edge with put=1 && ready=1;
  // the product is released on a rising edge with get=1 && result_valid=1.
  typedef enum logic [1:0] {
    S_W4A  = 2'd0,
    S_W4B  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_operand;
  logic [WIDTH:0]     w_sum;
  logic [PW-1:0]      w_shift;
  logic [PW-1:0]      w_step;
  logic               w_last;

`ifdef SERIAL_MULT_SIGNED_EN
  logic               r_sign;

  // The most negative input negates to itself, which read unsigned is the correct magnitude.
  assign w_operand = idata[WIDTH-1] ? (~idata + WIDTH'(1)) : idata;
  assign w_step    = (w_last && r_sign) ? (~w_shift + PW'(1)) : w_shift;
`else
  assign w_operand = idata;
  assign w_step    = w_shift;
`endif

  assign w_sum   = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_shift = {w_sum, r_b[WIDTH-1:1]};
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_W4A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      S_W4A: begin
        ready = 1'b1;
        if (put) w_state_nxt = S_W4B;
      end
      S_W4B: begin
        ready = 1'b1;
        if (put) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (get) w_state_nxt = S_W4A;
      end
      default: w_state_nxt = S_W4A;
    endcase
  end

  assign result = (r_state == S_DONE) ? {r_acc, r_b} : '0;

  // Product forms in {r_acc, r_b}: multiplier bits shift out of r_b as product bits shift in.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
`ifdef SERIAL_MULT_SIGNED_EN
      r_sign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_W4A: begin
          if (put) begin
            r_a <= w_operand;
`ifdef SERIAL_MULT_SIGNED_EN
            r_sign <= idata[WIDTH-1];
`endif
          end
        end
        S_W4B: begin
          if (put) begin
            r_b   <= w_operand;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef SERIAL_MULT_SIGNED_EN
            r_sign <= r_sign ^ idata[WIDTH-1];
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_step[PW-1:WIDTH];
          r_b   <= w_step[WIDTH-1:0];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_seq.sv
// Self-checking bench for serial_mult_seq: WIDTH=8 instance against a cycle model, plus a WIDTH=16 instance.
// Honours SERIAL_MULT_SIGNED_EN when defined for the build.
module tb_serial_mult_seq;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        put, get;
  logic [7:0]  idata;
  logic        ready, busy, result_valid;
  logic [15:0] result;
  logic        put16, get16;
  logic [15:0] idata16;
  logic        ready16, busy16, rv16;
  logic [31:0] result16;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  serial_mult_seq #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_b(rst_b), .put(put), .idata(idata), .get(get),
    .ready(ready), .busy(busy), .result(result), .result_valid(result_valid)
  );

  serial_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_b(rst_b), .put(put16), .idata(idata16), .get(get16),
    .ready(ready16), .busy(busy16), .result(result16), .result_valid(rv16)
  );

  function automatic logic [15:0] prod8(input logic [7:0] a, input logic [7:0] b);
`ifdef SERIAL_MULT_SIGNED_EN
    longint sa = a[7] ? longint'(a) - 256 : longint'(a);
    longint sb = b[7] ? longint'(b) - 256 : longint'(b);
    return 16'(sa * sb);
`else
    return 16'(longint'(a) * longint'(b));
`endif
  endfunction

  function automatic logic [31:0] prod16(input logic [15:0] a, input logic [15:0] b);
`ifdef SERIAL_MULT_SIGNED_EN
    longint sa = a[15] ? longint'(a) - 65536 : longint'(a);
    longint sb = b[15] ? longint'(b) - 65536 : longint'(b);
    return 32'(sa * sb);
`else
    return 32'(longint'(a) * longint'(b));
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle model: phase 0 wait A, 1 wait B, 2 computing, 3 holding product.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [7:0]  m_a = '0;
  logic [15:0] m_prod = '0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_prod  <= '0;
    end else begin
      case (m_phase)
        0: if (put) begin m_a <= idata; m_phase <= 1; end
        1: if (put) begin m_prod <= prod8(m_a, idata); m_cnt <= 8; m_phase <= 2; end
        2: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_phase <= 3;
        end
        default: if (get) m_phase <= 0;
      endcase
    end
  end

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_b) begin
      check("ready", {31'd0, ready}, {31'd0, m_phase < 2});
      check("busy", {31'd0, busy}, {31'd0, m_phase == 2});
      check("result_valid", {31'd0, result_valid}, {31'd0, m_phase == 3});
      check("result", {16'd0, result}, (m_phase == 3) ? {16'd0, m_prod} : 32'd0);
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard got %h expected none queued", result);
        end else begin
          check("scoreboard", {16'd0, result}, {16'd0, exp_q.pop_front()});
        end
      end
      prev_valid = result_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Driver tasks begin and end just after a falling edge.
  task automatic put_op(input logic [7:0] v);
    put = 1'b1;
    idata = v;
    @(negedge clk);
    put = 1'b0;
    idata = 8'($urandom);
  endtask

  task automatic do_get();
    get = 1'b1;
    @(negedge clk);
    get = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid got timeout expected valid within 200 cycles");
    end
  endtask

  task automatic mult(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int n;
    exp_q.push_back(exp);
    put_op(a);
    put_op(b);
    wait_valid(n);
    check({name, "_latency"}, n, 8);
    check(name, {16'd0, result}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int vc;
    logic [7:0] a, b;
    logic [15:0] a16, b16;
    put = 1'b0; get = 1'b0; idata = '0;
    put16 = 1'b0; get16 = 1'b0; idata16 = '0;

    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);

    mult("p3x5", 8'd3, 8'd5, 16'h000F);
    do_get();
    check("after_get_result", {16'd0, result}, 32'd0);
    check("after_get_ready", {31'd0, ready}, 32'd1);

`ifdef SERIAL_MULT_SIGNED_EN
    mult("pFFxFF", 8'hFF, 8'hFF, 16'h0001);
`else
    mult("pFFxFF", 8'hFF, 8'hFF, 16'hFE01);
`endif
    do_get();

    // Zero operand, with put held high through CALC and DONE carrying junk data.
    exp_q.push_back(16'h0000);
    put_op(8'h00);
    put_op(8'hA5);
    put = 1'b1;
    idata = 8'h77;
    wait_valid(n);
    check("zero_latency", n, 8);
    repeat (3) @(negedge clk);
    check("zero_hold_valid", {31'd0, result_valid}, 32'd1);
    check("zero_result", {16'd0, result}, 32'd0);
    put = 1'b0;
    do_get();

    // Asynchronous reset in the middle of a computation.
    put_op(8'd7);
    put_op(8'd9);
    repeat (4) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("async_ready", {31'd0, ready}, 32'd1);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_valid", {31'd0, result_valid}, 32'd0);
    check("async_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);
    mult("p2x6", 8'd2, 8'd6, 16'h000C);
    do_get();

    // put and get together in DONE: the put must be dropped.
    mult("p3x3", 8'd3, 8'd3, 16'h0009);
    put = 1'b1;
    idata = 8'h55;
    get = 1'b1;
    @(negedge clk);
    put = 1'b0;
    get = 1'b0;
    check("drop_ready", {31'd0, ready}, 32'd1);
    mult("p4x4", 8'd4, 8'd4, 16'h0010);
    do_get();

    // get held high: product visible for exactly one cycle.
    exp_q.push_back(16'h0084);
    get = 1'b1;
    put_op(8'd12);
    put_op(8'd11);
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) vc++;
    end
    check("get_held_visible_cycles", vc, 1);
    get = 1'b0;

`ifdef SERIAL_MULT_SIGNED_EN
    mult("pFDx05", 8'hFD, 8'h05, 16'hFFF1);
    do_get();
    mult("p80x80", 8'h80, 8'h80, 16'h4000);
    do_get();
    mult("p80x01", 8'h80, 8'h01, 16'hFF80);
    do_get();
`else
    mult("pFDx05", 8'hFD, 8'h05, 16'h04F1);
    do_get();
`endif

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) a = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'hFF;
      if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h00;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_q.push_back(prod8(a, b));
      put_op(a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      put_op(b);
      wait_valid(n);
      check("rand_latency", n, 8);
      repeat ($urandom_range(0, 3)) begin
        put = 1'($urandom_range(0, 1));
        idata = 8'($urandom);
        @(negedge clk);
      end
      put = 1'b0;
      do_get();
    end
    check("queue_drained", exp_q.size(), 0);

    // WIDTH=16 instance: all-ones operands, then a few random products.
    for (int i = 0; i < 5; i++) begin
      a16 = (i == 0) ? 16'hFFFF : 16'($urandom);
      b16 = (i == 0) ? 16'hFFFF : 16'($urandom);
      put16 = 1'b1;
      idata16 = a16;
      @(negedge clk);
      idata16 = b16;
      @(negedge clk);
      put16 = 1'b0;
      n = 0;
      while (!rv16 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("w16_latency", n, 16);
`ifdef SERIAL_MULT_SIGNED_EN
      check("w16_result", result16, (i == 0) ? 32'h0000_0001 : prod16(a16, b16));
`else
      check("w16_result", result16, (i == 0) ? 32'hFFFE_0001 : prod16(a16, b16));
`endif
      get16 = 1'b1;
      @(negedge clk);
      get16 = 1'b0;
      check("w16_after_get", result16, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mult_seq.md
Name: serial_mult_seq

Overview:
- Parametrised successor to the 8-bit put/get multiplier.
- Operand width is set by WIDTH. The product is computed by a shift-and-add datapath, one multiplier bit per cycle, instead of a single-cycle combinational multiplier.
- Two operands are loaded through the same put/ready handshake. The product is held until the consumer pulses get.
- Sits between the serial operand source and the result consumer in the arithmetic test designs.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2. The result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- put  input  1  operand strobe; accepted only while ready=1.
- idata  input  WIDTH  operand value, sampled on an accepted put.
- get  input  1  result consume strobe; effective only while result_valid=1.
- ready  output  1  high in W4A and W4B.
- busy  output  1  high in CALC.
- result  output  2*WIDTH  product while result_valid=1, otherwise all zeros.
- result_valid  output  1  high in DONE.

Behaviour:
- Clock and reset: clock clk; reset rst_b, asynchronous, active-low.
- Reset values:
  - State = W4A.
  - Operand A register, operand B register, accumulator and counter all cleared to 0.
  - ready=1, busy=0, result_valid=0, result=0.
- States: W4A -> W4B -> CALC -> DONE -> W4A.
- W4A:
  - put=1: capture idata as A, go to W4B.
  - Otherwise stay.
- W4B:
  - put=1: capture idata as B, clear accumulator and counter, go to CALC.
  - Otherwise stay.
- CALC, executed once per cycle:
  - If B bit 0 is 1, add A to the upper WIDTH+1 bits of the accumulator.
  - Shift the {carry, accumulator, B} combination right by 1.
  - Increment the counter.
  - When the counter reaches WIDTH-1, go to DONE on the same edge as the final step.
- Latency: if B is accepted on edge k, result_valid rises after edge k+WIDTH. CALC therefore lasts exactly WIDTH cycles, independent of operand values.
- Arithmetic:
  - Unsigned; no overflow is possible; the full 2*WIDTH-bit product is retained.
  - The adder is WIDTH+1 bits wide to keep the carry.
- DONE:
  - result holds the product and stays stable until consumed.
  - get=1 on an edge: go to W4A; result_valid and result fall after that edge.
- Ignored events:
  - put is ignored and registers are unchanged in CALC and DONE (ready=0).
  - get is ignored outside DONE.
- Simultaneous events:
  - put and get together in DONE: get is honoured, put is dropped.
  - A put on the cycle after get is accepted as a new operand A.
- Reset mid-operation: asserting rst_b low in any state, including mid-CALC, returns to W4A immediately. The partial result is discarded and every output goes to its reset value without waiting for clk.
- idata is sampled only on accepted put edges; its value at other times is don't-care.

Optional Feature:
- Macro SERIAL_MULT_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On capture, each operand is stored as its magnitude, and the XOR of the two sign bits is recorded.
  - CALC runs the unsigned shift-add on the magnitudes.
  - On entry to DONE, the product is negated in 2*WIDTH bits if the recorded sign is 1.
  - The most negative value (e.g. 8'h80) has magnitude 2^(WIDTH-1); this must be handled correctly, e.g. 8'h80*8'h80 = 16'h4000.
  - Latency stays exactly WIDTH cycles after B is accepted; the negation is folded into the last CALC edge.
- Not defined: pure unsigned behaviour as above; there is no sign logic or sign register.

Test Plan:
- WIDTH=8, put 3 then put 5 -> busy for 8 cycles, then result_valid=1 with result=16'h000F. After get, result=0 and ready=1.
- WIDTH=8, put 8'hFF then put 8'hFF -> result=16'hFE01. Also WIDTH=16, put 16'hFFFF twice -> 32'hFFFE0001, with valid exactly 16 cycles after the second put.
- Put 0 then put 8'hA5 -> result=0 with result_valid=1 after exactly 8 cycles. Put pulsed during CALC and DONE with idata=8'h77 -> product unchanged, no state advance.
- Assert rst_b low at CALC cycle 4 of 7*9 -> all outputs at reset values asynchronously. After release, 2*6 -> 16'h000C.
- In DONE, drive put and get together, then put 4 and put 4 back-to-back -> first put is dropped, next result=16'h0010. Hold get high continuously -> each product is visible for exactly one cycle.
- Put 8'hFD then put 5:
  - With SERIAL_MULT_SIGNED_EN -> 16'hFFF1 (-15).
  - Without it -> 16'h04F1 (1265).
  - With the macro, also 8'h80*8'h80 -> 16'h4000 and 8'h80*8'h01 -> 16'hFF80.
